// File: rtl/pif_reg_decoder.sv
// Register-decode stage behind the I2C slave byte engine: tagged-byte pointer/data
// decoding into a small register file that drives the LED flasher controls.
module pif_reg_decoder #(
  parameter logic [5:0] ID_VALUE = 6'h2A,
  parameter int         NUM_REGS = 5
) (
  input  logic       clk,
  input  logic       GSRn,
  input  logic       rx_start,
  input  logic       rx_rw,
  input  logic       rx_stop,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_req,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [1:0] led_mode,
  output logic [5:0] led_period,
  output logic       cfg_wr
);

  localparam logic [1:0] A_ADDR = 2'b00;
  localparam logic [1:0] D_ADDR = 2'b01;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t     state;
  logic [5:0] ptr;
  logic [5:0] scratch;
  logic [5:0] err_cnt;
  logic [5:0] rd_val;
  logic       wr_ok;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3F) ? v : v + 6'd1;
  endfunction

  function automatic logic is_mapped(input logic [5:0] a);
    return ({26'd0, a} < NUM_REGS);
  endfunction

  // Read mux and write permission for the register the pointer selects.
  always_comb begin
    rd_val = 6'd0;
    wr_ok  = 1'b0;
    if (is_mapped(ptr)) begin
      case (ptr)
        6'd0:    rd_val = ID_VALUE;
        6'd1:    begin rd_val = scratch;          wr_ok = 1'b1; end
        6'd2:    begin rd_val = {4'd0, led_mode}; wr_ok = 1'b1; end
        6'd3:    begin rd_val = led_period;       wr_ok = 1'b1; end
        6'd4:    rd_val = err_cnt;
        default: rd_val = 6'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!GSRn) begin
      state      <= IDLE;
      ptr        <= 6'd0;
      scratch    <= 6'd0;
      err_cnt    <= 6'd0;
      led_mode   <= 2'd0;
      led_period <= 6'd16;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      cfg_wr     <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      cfg_wr   <= 1'b0;
      // Bytes and read requests are handled in the state held before any transition.
      case (state)
        WR: begin
          if (rx_valid) begin
            case (rx_data[7:6])
              A_ADDR: ptr <= rx_data[5:0];
              D_ADDR: begin
                if (wr_ok) begin
                  case (ptr)
                    6'd1:    scratch    <= rx_data[5:0];
                    6'd2:    led_mode   <= rx_data[1:0];
                    default: led_period <= rx_data[5:0];
                  endcase
                  cfg_wr <= (ptr != 6'd1);
                end else begin
                  err_cnt <= sat_inc(err_cnt);
                end
                ptr <= ptr + 6'd1;
              end
              default: err_cnt <= sat_inc(err_cnt);
            endcase
          end
        end
        RD: begin
          if (tx_req) begin
            tx_valid <= 1'b1;
            tx_data  <= {2'b01, rd_val};
            ptr      <= ptr + 6'd1;
          end
        end
        default: ;
      endcase
      if (rx_start) begin
        state <= rx_rw ? RD : WR;
      end else if (rx_stop) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pif_reg_decoder.sv
// Scoreboard bench for pif_reg_decoder: a behavioural register-file model predicts
// every output; a monitor process compares DUT outputs after each rising edge.
module tb_pif_reg_decoder;

  logic       clk = 1'b0;
  logic       GSRn = 1'b0;
  logic       rx_start = 1'b0, rx_rw = 1'b0, rx_stop = 1'b0, rx_valid = 1'b0, tx_req = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_valid, cfg_wr;
  logic [7:0] tx_data;
  logic [1:0] led_mode;
  logic [5:0] led_period;

  always #5 clk = ~clk;

  pif_reg_decoder #(.ID_VALUE(6'h2A), .NUM_REGS(5)) dut (
    .clk(clk), .GSRn(GSRn), .rx_start(rx_start), .rx_rw(rx_rw), .rx_stop(rx_stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req), .tx_valid(tx_valid),
    .tx_data(tx_data), .led_mode(led_mode), .led_period(led_period), .cfg_wr(cfg_wr)
  );

  typedef struct {
    int         stamp;
    logic [7:0] data;
  } tx_exp_t;

  tx_exp_t tx_q[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  bit      mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: session state 0 idle, 1 write, 2 read; registers as plain values.
  int         m_ptr, m_err, m_st;
  logic [5:0] m_scr, m_period;
  logic [1:0] m_mode;
  logic [7:0] m_txd;
  logic       m_txv, m_cfg;

  function automatic logic [5:0] m_read(input int a);
    case (a)
      0:       return 6'h2A;
      1:       return m_scr;
      2:       return {4'd0, m_mode};
      3:       return m_period;
      4:       return 6'(m_err);
      default: return 6'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic g, s, rw, sp, v, input logic [7:0] d, input logic r);
    int tag, pl;
    m_txv = 1'b0;
    m_cfg = 1'b0;
    if (!g) begin
      m_ptr = 0; m_err = 0; m_st = 0; m_scr = 0; m_mode = 0; m_period = 6'd16; m_txd = 8'h00;
      return;
    end
    tag = int'(d[7:6]);
    pl  = int'(d[5:0]);
    if (m_st == 1 && v) begin
      if (tag == 0) begin
        m_ptr = pl;
      end else if (tag == 1) begin
        if (m_ptr == 1) m_scr = 6'(pl);
        else if (m_ptr == 2) begin m_mode = 2'(pl % 4); m_cfg = 1'b1; end
        else if (m_ptr == 3) begin m_period = 6'(pl); m_cfg = 1'b1; end
        else m_err = (m_err < 63) ? m_err + 1 : 63;
        m_ptr = (m_ptr + 1) % 64;
      end else begin
        m_err = (m_err < 63) ? m_err + 1 : 63;
      end
    end
    if (m_st == 2 && r) begin
      m_txv = 1'b1;
      m_txd = 8'h40 + 8'(m_read(m_ptr));
      tx_q.push_back('{stamp: cyc + 1, data: m_txd});
      m_ptr = (m_ptr + 1) % 64;
    end
    if (s) m_st = rw ? 2 : 1;
    else if (sp) m_st = 0;
  endtask

  task automatic drive(input logic g, s, rw, sp, v, input logic [7:0] d, input logic r);
    @(negedge clk);
    model_step(g, s, rw, sp, v, d, r);
    GSRn = g; rx_start = s; rx_rw = rw; rx_stop = sp; rx_valid = v; rx_data = d; tx_req = r;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    drive(1, 0, 0, 0, 1, d, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: continuous output comparison plus scoreboard pop on every read byte.
  initial begin
    tx_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("tx_valid", tx_valid, m_txv);
        chk("tx_data_hold", tx_data, m_txd);
        chk("led_mode", led_mode, m_mode);
        chk("led_period", led_period, m_period);
        chk("cfg_wr", cfg_wr, m_cfg);
        if (tx_valid === 1'b1) begin
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %0h expected none (cycle %0d)", tx_data, cyc);
          end else begin
            e = tx_q.pop_front();
            chk("tx_latency", cyc, e.stamp);
            chk("tx_byte", tx_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    int t, pl;
    logic [7:0] d;
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    settle();
    mon_en = 1'b1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_led_mode", led_mode, 2'd0);
    chk("rst_led_period", led_period, 6'd16);
    chk("rst_cfg_wr", cfg_wr, 1'b0);

    // Mode write through address byte then data byte.
    drive(1, 1, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h02);
    wr_byte(8'h41);
    settle();
    chk("tp1_led_mode", led_mode, 2'd1);
    drive(1, 0, 0, 1, 0, 8'h00, 0);
    idle();

    // Period write followed by a write to read-only register 4.
    drive(1, 1, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h03);
    wr_byte(8'h45);
    wr_byte(8'h6A);
    settle();
    chk("tp2_led_period", led_period, 6'd5);
    drive(1, 0, 0, 1, 0, 8'h00, 0);

    // Back-to-back reads from pointer 0.
    drive(1, 1, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h00);
    drive(1, 0, 0, 1, 0, 8'h00, 0);
    drive(1, 1, 1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    settle();
    chk("tp3_id_byte", tx_data, 8'h6A);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    drive(1, 0, 0, 1, 0, 8'h00, 0);

    // Unmapped write at 63 wraps the pointer; repeated START into a read returns ID.
    drive(1, 1, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h3F);
    wr_byte(8'h55);
    drive(1, 1, 1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    settle();
    chk("tp4_wrap_id", tx_data, 8'h6A);
    drive(1, 0, 0, 1, 0, 8'h00, 0);

    // Illegal tags saturate the error counter.
    drive(1, 1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 70; i++) wr_byte(8'hC0);
    wr_byte(8'h04);
    drive(1, 1, 1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    settle();
    chk("tp5_err_sat", tx_data, 8'h7F);
    drive(1, 0, 0, 1, 0, 8'h00, 0);

    // Reset lands on the same edge as a mode write.
    drive(1, 1, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h02);
    drive(0, 0, 0, 0, 1, 8'h41, 0);
    settle();
    chk("tp6_rst_mode", led_mode, 2'd0);
    chk("tp6_rst_txdata", tx_data, 8'h00);
    wr_byte(8'h41);
    drive(1, 1, 1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 0, 0, 8'h00, 1);
    settle();
    chk("tp6_ptr_zero", tx_data, 8'h6A);

    // Randomized traffic, including coincident control pulses and resets.
    for (int i = 0; i < 800; i++) begin
      t  = int'($urandom_range(0, 9));
      pl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 5));
      if (t < 4) d = {2'b00, 6'(pl)};
      else if (t < 9) d = {2'b01, 6'(pl)};
      else d = {1'b1, 1'($urandom_range(0, 1)), 6'(pl)};
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
    end

    idle();
    idle();
    idle();
    settle();
    chk("tx_queue_empty", tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
